card_shoe: RTL and testbench

- Deck server for the Blackjack game controller: holds a 52-card deck, shuffles it in hardware, and returns one card per draw request.
- Uses the same card encoding as the game: 1=Ace ... 10=Ten, 11=Jack, 12=Queen, 13=King, 0=no card.
- Replaces the in-controller random indexing of the deck with a deterministic, seedable shuffle. Game benches can therefore reproduce hands.

---
 rtl/card_shoe.sv | 124 ++++++++++++
 tb/tb_card_shoe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/card_shoe.sv
// 52-card deck server: hardware Fisher-Yates shuffle driven by a 16-bit LFSR,
// one card returned per accepted draw request.
module card_shoe #(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        shuffle,
  input  logic [15:0] seed,
  input  logic        draw,
  output logic [3:0]  card,
  output logic        card_valid,
  output logic        draw_err,
  output logic        busy,
  output logic        shuffle_done,
  output logic        empty,
  output logic [5:0]  remaining
);

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned CARD_W    = 4;
  localparam int unsigned PTR_W     = 6;
  localparam logic [PTR_W-1:0] DECK_LAST  = PTR_W'(DECK_SIZE - 1);
  localparam logic [PTR_W-1:0] DECK_COUNT = PTR_W'(DECK_SIZE);

  typedef enum logic [1:0] {IDLE, SHUFFLE, DONE} state_t;

  state_t            state_q, state_d;
  logic [CARD_W-1:0] deck_q [DECK_SIZE];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [PTR_W-1:0]  idx_q, idx_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [PTR_W-1:0]  mask_c, j_c;
  logic              swap_c, draw_ok_c, draw_rej_c;

  // Smallest all-ones mask covering idx, so rejection sampling stays unbiased.
  always_comb begin
    mask_c = PTR_W'(1);
    if      (idx_q >= PTR_W'(32)) mask_c = PTR_W'(63);
    else if (idx_q >= PTR_W'(16)) mask_c = PTR_W'(31);
    else if (idx_q >= PTR_W'(8))  mask_c = PTR_W'(15);
    else if (idx_q >= PTR_W'(4))  mask_c = PTR_W'(7);
    else if (idx_q >= PTR_W'(2))  mask_c = PTR_W'(3);
    j_c = lfsr_q[PTR_W-1:0] & mask_c;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    idx_d      = idx_q;
    lfsr_d     = lfsr_q;
    swap_c     = 1'b0;
    draw_ok_c  = 1'b0;
    draw_rej_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (shuffle) begin
          state_d    = SHUFFLE;
          lfsr_d     = (seed == 16'h0000) ? DEFAULT_SEED : seed;
          idx_d      = DECK_LAST;
          top_d      = '0;
          draw_rej_c = draw;
        end else if (draw) begin
          if (top_q < DECK_COUNT) begin
            draw_ok_c = 1'b1;
            top_d     = top_q + PTR_W'(1);
          end else begin
            draw_rej_c = 1'b1;
          end
        end
      end
      SHUFFLE: begin
        draw_rej_c = draw;
        lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (j_c <= idx_q) begin
          swap_c = 1'b1;
          idx_d  = idx_q - PTR_W'(1);
          if (idx_q == PTR_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        draw_rej_c = draw;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, deck storage and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      top_q        <= '0;
      idx_q        <= '0;
      lfsr_q       <= DEFAULT_SEED;
      card         <= '0;
      card_valid   <= 1'b0;
      draw_err     <= 1'b0;
      busy         <= 1'b0;
      shuffle_done <= 1'b0;
      empty        <= 1'b0;
      remaining    <= DECK_COUNT;
      for (int k = 0; k < DECK_SIZE; k++) deck_q[k] <= CARD_W'(k % 13 + 1);
    end else begin
      state_q      <= state_d;
      top_q        <= top_d;
      idx_q        <= idx_d;
      lfsr_q       <= lfsr_d;
      card_valid   <= draw_ok_c;
      draw_err     <= draw_rej_c;
      busy         <= (state_d == SHUFFLE);
      shuffle_done <= (state_d == DONE);
      empty        <= (top_d == DECK_COUNT);
      remaining    <= DECK_COUNT - top_d;
      if (draw_ok_c) card <= deck_q[top_q];
      for (int k = 0; k < DECK_SIZE; k++) begin
        if (swap_c && PTR_W'(k) == idx_q)    deck_q[k] <= deck_q[j_c];
        else if (swap_c && PTR_W'(k) == j_c) deck_q[k] <= deck_q[idx_q];
      end
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Directed + randomized bench for card_shoe against a transaction-level deck model.
module tb_card_shoe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        shuffle = 1'b0;
  logic [15:0] seed = 16'h0;
  logic        draw = 1'b0;
  logic [3:0]  card;
  logic        card_valid, draw_err, busy, shuffle_done, empty;
  logic [5:0]  remaining;

  card_shoe dut (
    .clk(clk), .reset(reset), .shuffle(shuffle), .seed(seed), .draw(draw),
    .card(card), .card_valid(card_valid), .draw_err(draw_err), .busy(busy),
    .shuffle_done(shuffle_done), .empty(empty), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_deck [52];
  int m_top;
  int last_card;
  int rec [$];
  int seq_a [52];
  int seq_b [52];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 52; k++) m_deck[k] = k % 13 + 1;
    m_top = 0;
    last_card = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_card"}, int'(card), 0);
    chk({tag, "_valid"}, int'(card_valid), 0);
    chk({tag, "_err"}, int'(draw_err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(shuffle_done), 0);
    chk({tag, "_empty"}, int'(empty), 0);
    chk({tag, "_remaining"}, int'(remaining), 52);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    #1 chk_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle with draw = d; checks the resulting pulse and counters.
  task automatic draw_cycle(input bit d);
    bit acc;
    bit rej;
    int exp_card;
    acc = d && (m_top < 52);
    rej = d && (m_top >= 52);
    exp_card = acc ? m_deck[m_top] : last_card;
    draw = d;
    @(posedge clk); #1;
    if (acc) begin
      m_top++;
      last_card = exp_card;
      rec.push_back(int'(card));
    end
    chk("draw_valid", int'(card_valid), int'(acc));
    chk("draw_err", int'(draw_err), int'(rej));
    chk("draw_card", int'(card), exp_card);
    chk("draw_remaining", int'(remaining), 52 - m_top);
    chk("draw_empty", int'(empty), int'(m_top == 52));
    draw = 1'b0;
  endtask

  task automatic draw_n(input int n);
    for (int k = 0; k < n; k++) draw_cycle(1'b1);
  endtask

  // Fisher-Yates on the model deck; returns the number of LFSR attempts.
  function automatic int model_shuffle(input logic [15:0] s);
    logic [15:0] lf;
    int i, j, m, n, t;
    lf = (s == 16'h0) ? 16'hACE1 : s;
    i = 51;
    n = 0;
    while (i >= 1) begin
      m = (1 << $clog2(i + 1)) - 1;
      j = int'(lf[5:0]) & m;
      lf = lfsr_step(lf);
      n++;
      if (j <= i) begin
        t = m_deck[i]; m_deck[i] = m_deck[j]; m_deck[j] = t;
        i--;
      end
    end
    m_top = 0;
    return n;
  endfunction

  // Starts a shuffle (optionally colliding with a draw) and follows it to completion.
  task automatic run_shuffle(input logic [15:0] s, input bit with_draw);
    int n, k;
    bit d_prev;
    bit seen;
    n = model_shuffle(s);
    shuffle = 1'b1; seed = s; draw = with_draw;
    @(posedge clk); #1;
    shuffle = 1'b0; draw = 1'b0;
    chk("shf_busy_rise", int'(busy), 1);
    chk("shf_collide_err", int'(draw_err), int'(with_draw));
    chk("shf_collide_valid", int'(card_valid), 0);
    seen = 1'b0;
    for (k = 1; k <= 2000 && !seen; k++) begin
      d_prev = 1'($urandom_range(0, 1));
      draw = d_prev;
      shuffle = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      draw = 1'b0; shuffle = 1'b0;
      chk("busy_draw_err", int'(draw_err), int'(d_prev));
      chk("busy_draw_valid", int'(card_valid), 0);
      if (shuffle_done) begin
        seen = 1'b1;
        chk("shf_cycles", k, n);
        chk("shf_busy_fall", int'(busy), 0);
      end else begin
        chk("shf_busy_high", int'(busy), 1);
      end
    end
    if (!seen) chk("shf_timeout", 0, 1);
    draw = 1'b1;
    @(posedge clk); #1;
    draw = 1'b0;
    chk("done_draw_err", int'(draw_err), 1);
    chk("done_draw_valid", int'(card_valid), 0);
    chk("done_pulse_once", int'(shuffle_done), 0);
    chk("done_busy", int'(busy), 0);
    chk("done_remaining", int'(remaining), 52);
  endtask

  task automatic record(output int seq [52]);
    rec.delete();
    draw_n(52);
    for (int k = 0; k < 52; k++) seq[k] = rec[k];
  endtask

  initial begin
    int cnt [14];
    int diff;
    int nrand;
    model_reset();
    do_reset();

    // Unshuffled deck deals in order, then runs dry.
    draw_n(14);
    draw_n(38);
    chk("empty_flag", int'(empty), 1);
    chk("empty_remaining", int'(remaining), 0);
    draw_cycle(1'b1);
    draw_cycle(1'b1);

    // Shuffle from empty with a colliding draw.
    run_shuffle(16'h1234, 1'b1);
    record(seq_a);
    for (int v = 0; v < 14; v++) cnt[v] = 0;
    for (int k = 0; k < 52; k++) if (seq_a[k] >= 0 && seq_a[k] <= 13) cnt[seq_a[k]]++;
    for (int v = 1; v <= 13; v++) chk($sformatf("id_count_%0d", v), cnt[v], 4);
    draw_cycle(1'b1);

    // Reproducibility from reset with the same seed.
    do_reset();
    run_shuffle(16'h1234, 1'b0);
    record(seq_b);
    diff = 0;
    for (int k = 0; k < 52; k++) if (seq_a[k] != seq_b[k]) diff++;
    chk("same_seed_repeat", diff, 0);

    // Seed 0 selects the default seed.
    do_reset();
    run_shuffle(16'h0000, 1'b0);
    record(seq_a);
    do_reset();
    run_shuffle(16'hACE1, 1'b0);
    record(seq_b);
    diff = 0;
    for (int k = 0; k < 52; k++) if (seq_a[k] != seq_b[k]) diff++;
    chk("zero_seed_default", diff, 0);

    // Random seeds, partial decks and sparse draws, reshuffling a permuted deck.
    for (int r = 0; r < 4; r++) begin
      run_shuffle(16'($urandom), 1'($urandom_range(0, 1)));
      nrand = $urandom_range(10, 70);
      for (int k = 0; k < nrand; k++) draw_cycle(1'($urandom_range(0, 3) != 0));
    end

    // Reset in the middle of a shuffle.
    void'(model_shuffle(16'hBEEF));
    shuffle = 1'b1; seed = 16'hBEEF;
    @(posedge clk); #1;
    shuffle = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("mid_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    draw_cycle(1'b1);
    chk("post_reset_card", int'(card), 1);
    draw_n(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
